// File: rtl/mips_pkg.sv
// Shared MIPS-style constants and the fetch queue entry type.
// FETCH_PREDECODE_EN adds a predecoded is_branch bit to each entry.
package mips_pkg;
  localparam int INSTR_W = 32;
  localparam int FETCH_PC_W = 64;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b000001;
  localparam logic [5:0] OP_LW    = 6'b000100;
  localparam logic [5:0] OP_SW    = 6'b000101;
  localparam logic [5:0] OP_BEQ   = 6'b000110;

  // pc is held at the widest supported width; unused upper bits stay zero
  typedef struct packed {
    logic [INSTR_W-1:0]    instr;
    logic [FETCH_PC_W-1:0] pc;
`ifdef FETCH_PREDECODE_EN
    logic                  is_branch;
`endif
  } fetch_entry_t;

`ifdef FETCH_PREDECODE_EN
  function automatic logic is_beq(input logic [INSTR_W-1:0] w);
    return w[31:26] == OP_BEQ;
  endfunction
`endif
endpackage

// File: rtl/fetch_fifo.sv
// Two-entry fetch queue with flush; head is driven straight from storage.
// Entry layout depends on FETCH_PREDECODE_EN via mips_pkg.
module fetch_fifo
  import mips_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output logic [1:0]   occ,
  output logic         head_valid,
  output fetch_entry_t head
);
  fetch_entry_t mem [2];
  logic wr_ptr;
  logic rd_ptr;
  logic do_pop;

  assign do_pop = pop && (occ != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop)
        rd_ptr <= ~rd_ptr;
      case ({push, do_pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign head_valid = occ != 2'd0;
  assign head       = mem[rd_ptr];
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, 1-cycle imem reads, 2-entry queue, branch redirect.
// FETCH_PREDECODE_EN adds the out_is_branch port.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc
`ifdef FETCH_PREDECODE_EN
  ,
  output logic              out_is_branch
`endif
);
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  logic              pop;
  logic [1:0]        occ;
  logic              head_valid;
  fetch_entry_t      push_data;
  fetch_entry_t      head;

  assign pop = head_valid && out_ready;

  // occ + inflight - pop < 2, rearranged to stay unsigned
  assign imem_req = !rst && !branch_taken &&
    (({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));
  assign imem_addr = pc;

  always_comb begin
    push_data       = '0;
    push_data.instr = imem_rdata;
    push_data.pc    = FETCH_PC_W'(inflight_pc);
`ifdef FETCH_PREDECODE_EN
    push_data.is_branch = is_beq(imem_rdata);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
    end else if (branch_taken) begin
      pc       <= branch_target & ~ADDR_W'(3);
      inflight <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        pc          <= pc + ADDR_W'(4);
        inflight_pc <= pc;
      end
    end
  end

  fetch_fifo u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (branch_taken),
    .push       (inflight),
    .push_data  (push_data),
    .pop        (pop),
    .occ        (occ),
    .head_valid (head_valid),
    .head       (head)
  );

  assign out_valid = head_valid;
  assign out_instr = head.instr;
  assign out_pc    = ADDR_W'(head.pc);
`ifdef FETCH_PREDECODE_EN
  assign out_is_branch = head.is_branch;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a queue-level model.
// Define FETCH_PREDECODE_EN to also cover out_is_branch.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
`ifdef FETCH_PREDECODE_EN
  logic        out_is_branch;
`endif

  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  instr_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc)
`ifdef FETCH_PREDECODE_EN
    ,
    .out_is_branch (out_is_branch)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] i;
    i = a >> 2;
    if (i >= 32'h100 && i[0]) return 32'h1800_0000 + i;
    return 32'h1000_0000 + i;
  endfunction

  // read data is meaningful only the cycle after a request
  always @(posedge clk)
    imem_rdata <= imem_req ? mem_word(imem_addr) : $urandom;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        q[$];
  int          m_inflight = 0;
  logic [31:0] m_ipc = '0;
  logic [31:0] m_pc = '0;

  always @(negedge clk) begin
    int pop;
    int req;
    pop = (q.size() != 0 && out_ready) ? 1 : 0;
    req = (!rst && !branch_taken &&
           (q.size() + m_inflight - pop < 2)) ? 1 : 0;
    if (chk_en) begin
      chk("valid", out_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("pc", out_pc, q[0].pc);
        chk("instr", out_instr, q[0].instr);
`ifdef FETCH_PREDECODE_EN
        chk("is_br", out_is_branch, q[0].instr[31:26] == 6'b000110);
`endif
      end
      chk("req", imem_req, req != 0);
      if (req != 0) chk("addr", imem_addr, m_pc);
    end
    if (rst) begin
      q.delete();
      m_inflight = 0;
      m_pc = 32'h0;
    end else if (branch_taken) begin
      q.delete();
      m_inflight = 0;
      m_pc = branch_target & ~32'h3;
    end else begin
      if (pop != 0) void'(q.pop_front());
      if (m_inflight != 0) q.push_back('{mem_word(m_ipc), m_ipc});
      if (req != 0) begin
        m_ipc = m_pc;
        m_pc = m_pc + 32'd4;
        m_inflight = 1;
      end else begin
        m_inflight = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic adv(input int n);
    repeat (n) step();
  endtask

  // leaves the bench in cycle 0: first cycle with rst low
  task automatic reset_release();
    step();
    rst = 1'b1;
    out_ready = 1'b1;
    branch_taken = 1'b0;
    adv(2);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    branch_taken = 1'b0;
    branch_target = '0;
    step();
    chk_en = 1'b1;
    step();
    @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_pc", out_pc, 0);
`ifdef FETCH_PREDECODE_EN
    chk("rst_is_br", out_is_branch, 0);
`endif

    reset_release();
    @(negedge clk);
    chk("c0_req", imem_req, 1);
    chk("c0_addr", imem_addr, 0);
    adv(2);
    @(negedge clk);
    chk("c2_valid", out_valid, 1);
    chk("c2_instr", out_instr, 32'h1000_0000);
    chk("c2_pc", out_pc, 0);
    for (int k = 1; k < 8; k++) begin
      step();
      @(negedge clk);
      chk("stream_valid", out_valid, 1);
      chk("stream_pc", out_pc, 4 * k);
    end

    for (int i = 0; i < 5; i++) begin
      step();
      out_ready = 1'b0;
    end
    @(negedge clk);
    chk("stall_req", imem_req, 0);
    chk("stall_valid", out_valid, 1);
    step();
    out_ready = 1'b1;
    adv(10);

    reset_release();
    adv(3);
    branch_taken = 1'b1;
    branch_target = 32'h43;
    @(negedge clk);
    chk("br1_pop_pc", out_pc, 4);
    step();
    branch_taken = 1'b0;
    @(negedge clk);
    chk("br1_t1_valid", out_valid, 0);
    chk("br1_t1_req", imem_req, 1);
    chk("br1_t1_addr", imem_addr, 32'h40);
    step();
    @(negedge clk);
    chk("br1_t2_valid", out_valid, 0);
    step();
    @(negedge clk);
    chk("br1_t3_valid", out_valid, 1);
    chk("br1_t3_pc", out_pc, 32'h40);
    chk("br1_t3_instr", out_instr, 32'h1000_0010);

    reset_release();
    adv(6);
    branch_taken = 1'b1;
    branch_target = 32'h200;
    @(negedge clk);
    chk("br2_pop_pc", out_pc, 32'h10);
    step();
    branch_taken = 1'b0;
    adv(2);
    @(negedge clk);
    chk("br2_valid", out_valid, 1);
    chk("br2_pc", out_pc, 32'h200);

`ifdef FETCH_PREDECODE_EN
    reset_release();
    branch_taken = 1'b1;
    branch_target = 32'h404;
    step();
    branch_taken = 1'b0;
    adv(2);
    @(negedge clk);
    chk("pd_beq_pc", out_pc, 32'h404);
    chk("pd_beq", out_is_branch, 1);
    step();
    @(negedge clk);
    chk("pd_lw_pc", out_pc, 32'h408);
    chk("pd_lw", out_is_branch, 0);
`endif

    reset_release();
    for (int i = 0; i < 3000; i++) begin
      step();
      rst = ($urandom_range(0, 99) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      branch_taken = ($urandom_range(0, 99) < 8);
      branch_target = $urandom_range(0, 32'h7ff);
    end
    step();
    rst = 1'b0;
    branch_taken = 1'b0;
    adv(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage that produces the instruction stream decoded by the control unit. It holds the program counter, issues word reads to a synchronous instruction memory with a fixed 1-cycle read latency, and buffers returned words in a 2-entry queue. It presents `{instr, pc}` to decode over a valid/ready handshake and redirects on a taken branch, discarding every stale fetch.

## Interface
- `ADDR_W`, default 32: program counter / instruction memory byte-address width.
- `RESET_PC`, default 0: PC value loaded on reset, word-aligned.
- `clk` input 1: the only clock; all state updates on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `imem_req` output 1: read strobe to instruction memory.
- `imem_addr` output ADDR_W: byte address of the read; bits [1:0] are always 0.
- `imem_rdata` input 32: read data, valid exactly 1 cycle after the `imem_req` cycle.
- `branch_taken` input 1: redirect request from the branch resolution logic.
- `branch_target` input ADDR_W: new PC when `branch_taken` is high; bits [1:0] are ignored and forced to 0.
- `out_valid` output 1: queue head is valid.
- `out_ready` input 1: decode accepts the head; a transfer occurs when `out_valid && out_ready`.
- `out_instr` output 32: instruction word at the queue head (opcode is bits [31:26]).
- `out_pc` output ADDR_W: byte address of `out_instr`.
- `out_is_branch` output 1: present only with `FETCH_PREDECODE_EN`.

## Operation
- State:
  - `pc` register;
  - `inflight` flag (a read was issued last cycle);
  - `inflight_pc`;
  - 2-entry FIFO of `{instr, pc}` with occupancy `occ` in the range 0..2.
- `pop = out_valid && out_ready`.
- Issue rule: `imem_req = !rst && !branch_taken && (occ + inflight - pop < 2)`. When `imem_req` is high:
  - `imem_addr = pc`;
  - `pc <= pc + 4`, wrapping modulo 2^ADDR_W;
  - `inflight <= 1` and `inflight_pc <= pc`.
  - Otherwise `inflight <= 0`.
- Response: when `inflight` is high, `{imem_rdata, inflight_pc}` is pushed into the FIFO at the end of the cycle. The issue rule guarantees the push never overflows.
- Push and pop in the same cycle: occupancy is unchanged and ordering is preserved.
- Redirect (`branch_taken` high), which has priority over all other actions:
  - `pc <= {branch_target[ADDR_W-1:2], 2'b00}`;
  - FIFO is cleared (`occ <= 0`);
  - `inflight <= 0`, so the response arriving next cycle is dropped;
  - no request is issued in that cycle.
- Redirect together with pop in the same cycle: the head counts as consumed by decode because it is older than the branch, and everything else is flushed.
- Redirect while the FIFO is empty and nothing is in flight is legal and is still a single-cycle action.
- Reset mid-operation clears the FIFO and `inflight`. A memory response returning in the first cycle after reset is ignored.

## Timing
- Reset values:
  - `pc = RESET_PC`;
  - `imem_req = 0`, `imem_addr = RESET_PC`;
  - `out_valid = 0`, `out_instr = 0`, `out_pc = 0`;
  - `out_is_branch = 0`;
  - `inflight = 0`, `occ = 0`.
- Request to `out_valid` latency is 2 cycles: request in cycle t, push at the end of t+1, visible at t+2.
- After a redirect in cycle t, the target is requested in t+1 and presented at t+3.
- With `out_ready` held high, throughput is 1 instruction per cycle.
- Outputs `out_*` are driven directly from FIFO registers and have no combinational path from `imem_rdata`.
- `imem_req` depends combinationally on `out_ready` and `branch_taken`.

## Configuration
- `FETCH_PREDECODE_EN` defined:
  - the FIFO stores an extra bit, `is_branch = (opcode == OP_BEQ)`, computed at push;
  - `out_is_branch` exposes it, aligned with `out_instr`.
- `FETCH_PREDECODE_EN` undefined: the port and the bit are absent, and behaviour is otherwise identical.

## Structure
- Shared package `mips_pkg` holds:
  - `INSTR_W = 32`;
  - opcode constants `OP_RTYPE = 6'b000000`, `OP_ADDI = 6'b000001`, `OP_LW = 6'b000100`, `OP_SW = 6'b000101`, `OP_BEQ = 6'b000110`;
  - the fetch-entry typedef `{instr, pc[, is_branch]}`.
- One sub-module: `fetch_fifo`, a 2-entry synchronous FIFO with a `flush` input, push/pop, `occ`, and head outputs.

## Test plan
- Reset release with memory[i] = 0x1000_0000 + i:
  - cycle 0: `imem_req = 1`, `imem_addr = 0`;
  - cycle 2: `out_valid = 1`, `out_instr = 0x1000_0000`, `out_pc = 0`.
- `out_ready` held high for 8 cycles: `out_pc` = 0, 4, 8, …, 28 on consecutive cycles, with no bubbles after the first valid.
- `out_ready` low for 5 cycles: `occ` reaches 2 and `imem_req` drops. On release, transfers resume in order with no lost or duplicated `pc`.
- `branch_taken` with target 0x43 while a read of 0x8 is in flight: the 0x8 word never appears, and `out_pc` = 0x40 appears exactly 3 cycles after the redirect.
- Redirect in the same cycle as a pop of pc 0x10: 0x10 counts as transferred, and the next transfer is the target.
- Under `FETCH_PREDECODE_EN`: an instruction with opcode 6'b000110 gives `out_is_branch = 1`, and opcode 6'b000100 gives 0.
